s27_core: RTL and testbench

- Small sequential control block with three state flops and a combinational next-state/output network (ISCAS-89 s27 function).
- Four single-bit primary inputs G0..G3 and one single-bit primary output G17.
- G17 is a Mealy output: it depends on the current state and the current inputs.
- Used as a compact scan/test-structure target and as a sequential glue-logic block.

---
 rtl/s27_core.sv | 54 +++++
 tb/tb_s27_core.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/s27_core.sv
// ISCAS-89 s27 sequential block: three state flops and a Mealy output G17
// computed from current state and the four primary inputs.
module s27_core (
  input  logic CK,
  input  logic RST_N,
  input  logic G0,
  input  logic G1,
  input  logic G2,
  input  logic G3,
  output logic G17
);

  logic r_g5;
  logic r_g6;
  logic r_g7;

  logic w_g8;
  logic w_g9;
  logic w_g10;
  logic w_g11;
  logic w_g12;
  logic w_g13;
  logic w_g14;
  logic w_g15;
  logic w_g16;

  // Feed-forward network from the flops; no path loops back without a flop.
  always_comb begin
    w_g14 = ~G0;
    w_g8  = w_g14 & r_g6;
    w_g12 = ~(G1 | r_g7);
    w_g15 = w_g12 | w_g8;
    w_g16 = G3 | w_g8;
    w_g9  = ~(w_g16 & w_g15);
    w_g11 = ~(r_g5 | w_g9);
    w_g10 = ~(w_g14 | w_g11);
    w_g13 = ~(G2 | w_g12);
  end

  assign G17 = ~w_g11;

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      r_g5 <= 1'b0;
      r_g6 <= 1'b0;
      r_g7 <= 1'b0;
    end else begin
      r_g5 <= w_g10;
      r_g6 <= w_g11;
      r_g7 <= w_g13;
    end
  end

endmodule

// File: tb/tb_s27_core.sv
// Bench for s27_core: directed table, async reset, exhaustive sweep over
// reachable states and alternating patterns, all checked via a scoreboard.
module tb_s27_core;

  logic CK;
  logic RST_N;
  logic G0, G1, G2, G3;
  logic G17;

  s27_core dut (
    .CK    (CK),
    .RST_N (RST_N),
    .G0    (G0),
    .G1    (G1),
    .G2    (G2),
    .G3    (G3),
    .G17   (G17)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  typedef struct {
    logic       g17;
    logic [2:0] nxt;
  } exp_t;

  typedef struct {
    bit         rst;   // reset before this row
    logic [3:0] in;    // {G0,G1,G2,G3}
    logic       g17;
    logic [2:0] nxt;   // {G5,G6,G7}
  } vec_t;

  exp_t       sb[$];
  logic [2:0] m_state;
  int         n_checks;
  int         n_errors;

  // Reference model: returns {G17, G10, G11, G13}.
  function automatic logic [3:0] model(input logic [2:0] st, input logic [3:0] in);
    logic g0, g1, g2, g3, g5, g6, g7;
    logic g8, g9, g10, g11, g12, g13, g14, g15, g16;
    {g0, g1, g2, g3} = in;
    {g5, g6, g7} = st;
    g14 = !g0;
    g8  = g14 && g6;
    g12 = !(g1 || g7);
    g15 = g12 || g8;
    g16 = g3 || g8;
    g9  = !(g16 && g15);
    g11 = !(g5 || g9);
    g10 = !(g14 || g11);
    g13 = !(g2 || g12);
    return {!g11, g10, g11, g13};
  endfunction

  function automatic logic [2:0] dut_state();
    return {dut.r_g5, dut.r_g6, dut.r_g7};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one input vector, check G17 combinationally, then check state after the edge.
  task automatic step(input string name, input logic [3:0] in, input bit use_model,
                      input logic g17_c, input logic [2:0] nxt_c);
    exp_t       e;
    logic [3:0] r;
    {G0, G1, G2, G3} = in;
    r = model(m_state, in);
    if (use_model) begin
      e.g17 = r[3];
      e.nxt = r[2:0];
    end else begin
      e.g17 = g17_c;
      e.nxt = nxt_c;
    end
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    check({name, " G17"}, {3'b0, G17}, {3'b0, e.g17});
    if ($isunknown(G17)) check({name, " G17 X"}, 4'd1, 4'd0);
    @(posedge CK);
    #1;
    check({name, " state"}, {1'b0, dut_state()}, {1'b0, e.nxt});
    m_state = e.nxt;
  endtask

  task automatic do_reset();
    {G0, G1, G2, G3} = 4'b0000;
    #2;
    RST_N = 1'b0;
    #1;
    check("reset state", {1'b0, dut_state()}, 4'd0);
    check("reset G17", {3'b0, G17}, 4'd1);
    #2;
    RST_N = 1'b1;
    m_state = 3'b000;
  endtask

  vec_t       tbl[$];
  logic [2:0] par_s[8];
  logic [3:0] par_i[8];
  bit         seen[8];
  int         bfs_q[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    RST_N    = 1'b1;
    {G0, G1, G2, G3} = 4'b0000;
    m_state  = 3'b000;

    tbl = '{
      '{1'b1, 4'b0000, 1'b1, 3'b000},
      '{1'b0, 4'b0000, 1'b1, 3'b000},
      '{1'b0, 4'b0000, 1'b1, 3'b000},
      '{1'b0, 4'b1000, 1'b1, 3'b100},
      '{1'b0, 4'b1100, 1'b1, 3'b101},
      '{1'b0, 4'b1110, 1'b1, 3'b100},
      '{1'b0, 4'b1111, 1'b1, 3'b100},
      '{1'b1, 4'b0001, 1'b0, 3'b010},
      '{1'b0, 4'b0000, 1'b0, 3'b010}
    };

    @(negedge CK);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      step($sformatf("tbl%0d", i), tbl[i].in, 1'b0, tbl[i].g17, tbl[i].nxt);
    end

    // Async reset mid-cycle from state 010 with G17 low.
    check("pre-async state", {1'b0, dut_state()}, 4'b0010);
    check("pre-async G17", {3'b0, G17}, 4'd0);
    #2;
    RST_N = 1'b0;
    #1;
    check("async state", {1'b0, dut_state()}, 4'd0);
    check("async G17", {3'b0, G17}, 4'd1);
    #1;
    RST_N   = 1'b1;
    m_state = 3'b000;
    step("post-async", 4'b0001, 1'b1, 1'b0, 3'b000);

    // Discover reachable states from reset with the model.
    for (int s = 0; s < 8; s++) seen[s] = 1'b0;
    seen[0] = 1'b1;
    bfs_q.push_back(0);
    while (bfs_q.size() > 0) begin
      int         s;
      logic [3:0] r;
      s = bfs_q.pop_front();
      for (int i = 0; i < 16; i++) begin
        r = model(3'(s), 4'(i));
        if (!seen[r[2:0]]) begin
          seen[r[2:0]]  = 1'b1;
          par_s[r[2:0]] = 3'(s);
          par_i[r[2:0]] = 4'(i);
          bfs_q.push_back(int'(r[2:0]));
        end
      end
    end

    for (int t = 0; t < 8; t++) begin
      if (seen[t]) begin
        for (int i = 0; i < 16; i++) begin
          logic [3:0] path[$];
          logic [2:0] cur;
          path = {};
          cur  = 3'(t);
          while (cur != 3'b000) begin
            path.push_front(par_i[cur]);
            cur = par_s[cur];
          end
          do_reset();
          foreach (path[k]) step("walk", path[k], 1'b1, 1'b0, 3'b000);
          step($sformatf("sweep s%0d i%0d", t, i), 4'(i), 1'b1, 1'b0, 3'b000);
        end
      end
    end

    do_reset();
    for (int c = 0; c < 10; c++) begin
      step($sformatf("alt%0d", c), (c % 2 == 0) ? 4'b0101 : 4'b1010, 1'b1, 1'b0, 3'b000);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
